twowire_dtm_serial: RTL and testbench
=====================================

// Module: twowire_dtm_serial
// PURPOSE
//  Serial link layer of the Two-Wire Debug DTM, directly upstream of the DTM core.
//  Recognises the connect key on the DIO line, frames start/command/parity, and dispatches cmd to the core.
//  It also streams payload bits between the DIO pad and the core's shift register, and owns DIO output-enable/turnaround.
// PARAMETERS
//  W_CMD        4      command field width in bits, MSB first on the wire
//  CONNECT_KEY  8'ha7  8-bit key that moves the link from DISCONNECTED to IDLE
//  TIMEOUT      72     payload cycle limit; used only when TWD_PAYLOAD_TIMEOUT_EN is defined
// PORTS
//  dck                input   1      debug clock; all state changes on posedge
//  drst_n             input   1      reset, asynchronous, active-low
//  dio_i              input   1      DIO pad input, sampled on posedge dck
//  dio_o              output  1      DIO pad output data
//  dio_oe             output  1      DIO pad output enable
//  connected          output  1      registered; high when state != DISCONNECTED
//  cmd                output  W_CMD  registered command; stable from DISPATCH until return to IDLE
//  cmd_vld            output  1      one-cycle pulse in DISPATCH
//  disconnect_now     input   1      from core; valid only while cmd_vld is high
//  cmd_payload_end    input   1      from core; last payload bit is consumed this cycle
//  serial_parity_err  output  1      one-cycle pulse on a bad command parity
//  serial_wdata       output  1      equals dio_i
//  serial_wdata_vld   output  1      high in state WDATA
//  serial_rdata       input   1      core's current read bit
//  serial_rdata_rdy   output  1      high in state RDATA
// BEHAVIOUR
//  Reset: state DISCONNECTED, key shifter 8'h00, cmd 0. All outputs are 0, except dio_o = serial_rdata (combinational).
//  DISCONNECTED: each cycle key_sr <= {key_sr[6:0], dio_i}.
//   - If {key_sr[6:0], dio_i} == CONNECT_KEY, go to IDLE.
//   - Overlapping/partial matches are valid (pure sliding window).
//  IDLE: dio_i=1 stays in IDLE. dio_i=0 is the start bit: go to CMD with bit_ctr = W_CMD-1.
//  CMD: shift dio_i into cmd, MSB first. Decrement bit_ctr; at 0, go to PARITY.
//  PARITY: dio_i must equal ^cmd (even parity over cmd + parity bit).
//   - Mismatch: pulse serial_parity_err, go to IDLE, no cmd_vld.
//   - Match: go to DISPATCH.
//  DISPATCH (1 cycle, cmd_vld=1), next state:
//   - disconnect_now -> DISCONNECTED, key_sr cleared
//   - cmd in {3,5,9} (writes) -> WDATA
//   - cmd in {1,2,4,7,8} (reads) -> TURN_A
//   - any other cmd -> IDLE
//  WDATA: serial_wdata_vld=1 every cycle. On cmd_payload_end, go to IDLE.
//  TURN_A: dio_oe=0 for one turnaround cycle, then RDATA.
//  RDATA: dio_oe=1, dio_o=serial_rdata, serial_rdata_rdy=1. On cmd_payload_end, go to TURN_B.
//  TURN_B: dio_oe=0 for one cycle, then IDLE.
//  dio_oe is high only in RDATA; the link never drives DIO outside RDATA.
//  Latency: start bit to cmd_vld = W_CMD+2 cycles. cmd_vld to first wdata bit = 1; to first rdata bit = 2.
//  Simultaneous events: cmd_payload_end with bit_ctr rollover has no meaning (no payload counter here); the core owns payload length.
//  Reset mid-operation: immediate return to DISCONNECTED; dio_oe drops asynchronously.
// CONFIGURATION
//  TWD_PAYLOAD_TIMEOUT_EN defined:
//   - 7-bit counter clears in DISPATCH and counts in WDATA/TURN_A/RDATA.
//   - On reaching TIMEOUT without cmd_payload_end: pulse serial_parity_err, dio_oe=0, go to IDLE.
//  Undefined: no counter; payload lasts until cmd_payload_end.
// STRUCTURE
//  twowire_defs.vh (shared with the core): CMD_* opcodes, CMD_IS_WRITE/CMD_IS_READ macros, CONNECT_KEY default.
//  State encoding is localparam, 4 bits.
//  Single flat module; no sub-module warranted.
// TESTING
//  1. Drive 1s, then 8'ha7 MSB first -> connected rises the cycle after the final bit; 8'ha6 -> stays low.
//  2. Connected; start, cmd 4'h1, parity 1 -> cmd_vld one pulse; TURN_A dio_oe=0; 32 cycles dio_oe=1 with dio_o = core IDCODE bits; TURN_B; IDLE.
//  3. Start, cmd 4'h1, parity 0 -> serial_parity_err one pulse, no cmd_vld, back in IDLE (next start bit accepted).
//  4. Start, cmd 4'h0, parity 0, core asserts disconnect_now -> connected low next cycle; a new 8'ha7 is required.
//  5. Start, cmd 4'h3, parity 0 -> serial_wdata_vld high until the stubbed core pulses cmd_payload_end after 32 bits; serial_wdata tracks dio_i; dio_oe stays 0.
//  6. drst_n low mid-RDATA -> dio_oe=0, connected=0 immediately; after release, the link stays disconnected until the key is sent.
//  7. With TWD_PAYLOAD_TIMEOUT_EN, core never ends payload -> IDLE and serial_parity_err after 72 cycles.

Source files
------------

// File: rtl/twowire_dtm_serial_pkg.sv
// ============================================================================
// Module      : twowire_dtm_serial_pkg
// Description : Shared types and opcodes for the Two-Wire Debug DTM serial link
//               layer and the DTM core (state encoding, command classes,
//               default connect key and parameter defaults).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package twowire_dtm_serial_pkg;

  // Parameter defaults shared with the core
  localparam int         W_CMD_DEFAULT       = 4;
  localparam logic [7:0] CONNECT_KEY_DEFAULT = 8'ha7;
  localparam int         TIMEOUT_DEFAULT     = 72;

  // Command opcodes
  localparam logic [15:0] CMD_NOP       = 16'd0;
  localparam logic [15:0] CMD_IDCODE    = 16'd1;
  localparam logic [15:0] CMD_RD_STATUS = 16'd2;
  localparam logic [15:0] CMD_WR_DTMCS  = 16'd3;
  localparam logic [15:0] CMD_RD_DTMCS  = 16'd4;
  localparam logic [15:0] CMD_WR_DMI    = 16'd5;
  localparam logic [15:0] CMD_RD_DMI    = 16'd7;
  localparam logic [15:0] CMD_RD_SBA    = 16'd8;
  localparam logic [15:0] CMD_WR_SBA    = 16'd9;

  // Link state encoding, 4 bits wide
  typedef enum logic [3:0] {
    ST_DISCONNECTED = 4'd0,
    ST_IDLE         = 4'd1,
    ST_CMD          = 4'd2,
    ST_PARITY       = 4'd3,
    ST_DISPATCH     = 4'd4,
    ST_WDATA        = 4'd5,
    ST_TURN_A       = 4'd6,
    ST_RDATA        = 4'd7,
    ST_TURN_B       = 4'd8
  } state_e;

  // Commands that carry a host-to-target payload
  function automatic logic cmd_is_write(input logic [15:0] c);
    return (c == CMD_WR_DTMCS) || (c == CMD_WR_DMI) || (c == CMD_WR_SBA);
  endfunction

  // Commands that return a target-to-host payload
  function automatic logic cmd_is_read(input logic [15:0] c);
    return (c == CMD_IDCODE) || (c == CMD_RD_STATUS) || (c == CMD_RD_DTMCS) ||
           (c == CMD_RD_DMI) || (c == CMD_RD_SBA);
  endfunction

endpackage

`default_nettype wire

// File: rtl/twowire_dtm_serial_if.sv
// ============================================================================
// Module      : twowire_dtm_serial_if
// Description : Link-layer to DTM-core handshake bundle. The master modport is
//               the serial link layer, the slave modport is the DTM core.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface twowire_dtm_serial_if #(
  parameter int W_CMD = 4
) ();

  logic [W_CMD-1:0] cmd;
  logic             cmd_vld;
  logic             disconnect_now;
  logic             cmd_payload_end;
  logic             serial_parity_err;
  logic             serial_wdata;
  logic             serial_wdata_vld;
  logic             serial_rdata;
  logic             serial_rdata_rdy;

  modport master (
    output cmd,
    output cmd_vld,
    output serial_parity_err,
    output serial_wdata,
    output serial_wdata_vld,
    output serial_rdata_rdy,
    input  disconnect_now,
    input  cmd_payload_end,
    input  serial_rdata
  );

  modport slave (
    input  cmd,
    input  cmd_vld,
    input  serial_parity_err,
    input  serial_wdata,
    input  serial_wdata_vld,
    input  serial_rdata_rdy,
    output disconnect_now,
    output cmd_payload_end,
    output serial_rdata
  );

endinterface

`default_nettype wire

// File: rtl/twowire_dtm_serial.sv
// ============================================================================
// Module      : twowire_dtm_serial
// Description : Serial link layer of the Two-Wire Debug DTM. Detects the
//               connect key on DIO, frames start/command/parity, dispatches
//               the command to the core, streams payload bits and owns the
//               DIO output enable and turnaround cycles.
//               Optional macro TWD_PAYLOAD_TIMEOUT_EN: abort a payload that
//               runs TIMEOUT cycles without cmd_payload_end.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module twowire_dtm_serial
  import twowire_dtm_serial_pkg::*;
#(
  parameter int         W_CMD       = W_CMD_DEFAULT,
  parameter logic [7:0] CONNECT_KEY = CONNECT_KEY_DEFAULT
`ifdef TWD_PAYLOAD_TIMEOUT_EN
  , parameter int       TIMEOUT     = TIMEOUT_DEFAULT
`endif
) (
  input  wire logic            dck,
  input  wire logic            drst_n,
  input  wire logic            dio_i,
  output logic                 dio_o,
  output logic                 dio_oe,
  output logic                 connected,
  twowire_dtm_serial_if.master core
);

  localparam int CTR_W = (W_CMD > 1) ? $clog2(W_CMD) : 1;

  state_e           state_q, state_d;
  logic [7:0]       key_sr_q, key_sr_d;
  logic [W_CMD-1:0] cmd_q, cmd_d;
  logic [CTR_W-1:0] bit_ctr_q, bit_ctr_d;

  // Registered outputs, each a decode of the next state
  logic connected_q, connected_d;
  logic cmd_vld_q, cmd_vld_d;
  logic parity_err_q, parity_err_d;
  logic wdata_vld_q, wdata_vld_d;
  logic rdata_rdy_q, rdata_rdy_d;
  logic dio_oe_q, dio_oe_d;

  logic [7:0] w_key_next;
  logic       w_timeout;

`ifdef TWD_PAYLOAD_TIMEOUT_EN
  logic [6:0] to_cnt_q, to_cnt_d;

  // Payload watchdog: cleared on dispatch, counts every payload/turnaround cycle
  always_comb begin
    to_cnt_d  = to_cnt_q;
    w_timeout = 1'b0;
    if (state_q == ST_DISPATCH) begin
      to_cnt_d = 7'd0;
    end else if ((state_q == ST_WDATA) || (state_q == ST_TURN_A) ||
                 (state_q == ST_RDATA)) begin
      to_cnt_d = to_cnt_q + 7'd1;
      if (!core.cmd_payload_end && (to_cnt_q == 7'(TIMEOUT - 1))) begin
        w_timeout = 1'b1;
      end
    end
  end

  // Watchdog counter register
  always_ff @(posedge dck or negedge drst_n) begin
    if (!drst_n) begin
      to_cnt_q <= 7'd0;
    end else begin
      to_cnt_q <= to_cnt_d;
    end
  end
`else
  assign w_timeout = 1'b0;
`endif

  assign w_key_next = {key_sr_q[6:0], dio_i};

  // Next-state, shifter and registered-output decode
  always_comb begin
    state_d      = state_q;
    key_sr_d     = key_sr_q;
    cmd_d        = cmd_q;
    bit_ctr_d    = bit_ctr_q;
    parity_err_d = 1'b0;

    case (state_q)
      ST_DISCONNECTED: begin
        // Pure sliding window: every DIO bit shifts in, match on any alignment
        key_sr_d = w_key_next;
        if (w_key_next == CONNECT_KEY) begin
          state_d = ST_IDLE;
        end
      end
      ST_IDLE: begin
        if (!dio_i) begin
          state_d   = ST_CMD;
          bit_ctr_d = CTR_W'(W_CMD - 1);
        end
      end
      ST_CMD: begin
        cmd_d     = (cmd_q << 1) | W_CMD'(dio_i);
        bit_ctr_d = bit_ctr_q - 1'b1;
        if (bit_ctr_q == '0) begin
          state_d = ST_PARITY;
        end
      end
      ST_PARITY: begin
        if (dio_i == ^cmd_q) begin
          state_d = ST_DISPATCH;
        end else begin
          state_d      = ST_IDLE;
          parity_err_d = 1'b1;
        end
      end
      ST_DISPATCH: begin
        if (core.disconnect_now) begin
          state_d  = ST_DISCONNECTED;
          key_sr_d = 8'h00;
        end else if (cmd_is_write(16'(cmd_q))) begin
          state_d = ST_WDATA;
        end else if (cmd_is_read(16'(cmd_q))) begin
          state_d = ST_TURN_A;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WDATA: begin
        if (core.cmd_payload_end) begin
          state_d = ST_IDLE;
        end
      end
      ST_TURN_A: begin
        state_d = ST_RDATA;
      end
      ST_RDATA: begin
        if (core.cmd_payload_end) begin
          state_d = ST_TURN_B;
        end
      end
      ST_TURN_B: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d  = ST_DISCONNECTED;
        key_sr_d = 8'h00;
      end
    endcase

    // A stalled payload is abandoned and reported through the error pulse
    if (w_timeout) begin
      state_d      = ST_IDLE;
      parity_err_d = 1'b1;
    end

    connected_d = (state_d != ST_DISCONNECTED);
    cmd_vld_d   = (state_d == ST_DISPATCH);
    wdata_vld_d = (state_d == ST_WDATA);
    rdata_rdy_d = (state_d == ST_RDATA);
    dio_oe_d    = (state_d == ST_RDATA);
  end

  // State and output registers; reset drops dio_oe immediately
  always_ff @(posedge dck or negedge drst_n) begin
    if (!drst_n) begin
      state_q      <= ST_DISCONNECTED;
      key_sr_q     <= 8'h00;
      cmd_q        <= '0;
      bit_ctr_q    <= '0;
      connected_q  <= 1'b0;
      cmd_vld_q    <= 1'b0;
      parity_err_q <= 1'b0;
      wdata_vld_q  <= 1'b0;
      rdata_rdy_q  <= 1'b0;
      dio_oe_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      key_sr_q     <= key_sr_d;
      cmd_q        <= cmd_d;
      bit_ctr_q    <= bit_ctr_d;
      connected_q  <= connected_d;
      cmd_vld_q    <= cmd_vld_d;
      parity_err_q <= parity_err_d;
      wdata_vld_q  <= wdata_vld_d;
      rdata_rdy_q  <= rdata_rdy_d;
      dio_oe_q     <= dio_oe_d;
    end
  end

  assign dio_o                  = core.serial_rdata;
  assign dio_oe                 = dio_oe_q;
  assign connected              = connected_q;
  assign core.cmd               = cmd_q;
  assign core.cmd_vld           = cmd_vld_q;
  assign core.serial_parity_err = parity_err_q;
  assign core.serial_wdata      = dio_i;
  assign core.serial_wdata_vld  = wdata_vld_q;
  assign core.serial_rdata_rdy  = rdata_rdy_q;

endmodule

`default_nettype wire

// File: tb/tb_twowire_dtm_serial.sv
// ============================================================================
// Module      : tb_twowire_dtm_serial
// Description : Self-checking bench for twowire_dtm_serial with a stub DTM
//               core. Expected commands, read bits and write bits are queued
//               when stimulus is driven and popped when the DUT produces them.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_twowire_dtm_serial;

  localparam int W_CMD = 4;

  logic dck    = 1'b0;
  logic drst_n = 1'b0;
  logic dio_i  = 1'b1;
  logic dio_o, dio_oe, connected;

  logic disc_en      = 1'b0;
  logic hold_payload = 1'b0;
  logic skip_rd      = 1'b0;
  logic [31:0] idcode = 32'h4BA0_0477;
  logic [5:0]  idx;

  int n_cmp = 0;
  int n_bad = 0;

  logic [W_CMD-1:0] exp_cmd_q[$];
  logic             exp_rd_q[$];
  logic             exp_wr_q[$];

  twowire_dtm_serial_if #(.W_CMD(W_CMD)) core_if ();

  twowire_dtm_serial #(
    .W_CMD       (W_CMD),
    .CONNECT_KEY (8'ha7)
  ) dut (
    .dck       (dck),
    .drst_n    (drst_n),
    .dio_i     (dio_i),
    .dio_o     (dio_o),
    .dio_oe    (dio_oe),
    .connected (connected),
    .core      (core_if.master)
  );

  always #5 dck = ~dck;

  // Stub core: 32-bit payloads, IDCODE returned LSB first
  always_ff @(posedge dck or negedge drst_n) begin
    if (!drst_n) begin
      idx <= 6'd0;
    end else if (core_if.cmd_vld) begin
      idx <= 6'd0;
    end else if (core_if.serial_wdata_vld || core_if.serial_rdata_rdy) begin
      idx <= idx + 6'd1;
    end
  end

  always_comb begin
    core_if.serial_rdata    = idcode[idx[4:0]];
    core_if.cmd_payload_end = !hold_payload &&
                              (core_if.serial_wdata_vld || core_if.serial_rdata_rdy) &&
                              (idx == 6'd31);
    core_if.disconnect_now  = disc_en && core_if.cmd_vld;
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Scoreboard: compare DUT output events against queued expectations
  always @(negedge dck) begin
    if (drst_n) begin
      if (core_if.cmd_vld) begin
        if (exp_cmd_q.size() == 0) check("cmd_vld_unexpected", 32'd1, 32'd0);
        else check("cmd", 32'(core_if.cmd), 32'(exp_cmd_q.pop_front()));
      end
      if (dio_oe && !skip_rd) begin
        if (exp_rd_q.size() == 0) check("dio_oe_unexpected", 32'd1, 32'd0);
        else check("rdata", 32'(dio_o), 32'(exp_rd_q.pop_front()));
      end
      if (core_if.serial_wdata_vld) begin
        if (exp_wr_q.size() == 0) check("wdata_vld_unexpected", 32'd1, 32'd0);
        else check("wdata", 32'(core_if.serial_wdata), 32'(exp_wr_q.pop_front()));
      end
    end
  end

  task automatic step(input logic b);
    dio_i = b;
    @(posedge dck);
    #1;
  endtask

  task automatic send_key(input logic [7:0] k);
    for (int i = 7; i >= 0; i--) step(k[i]);
  endtask

  task automatic send_cmd(input logic [3:0] c, input logic p, input logic expect_vld);
    if (expect_vld) exp_cmd_q.push_back(c);
    step(1'b0);
    for (int i = 3; i >= 0; i--) step(c[i]);
    step(p);
  endtask

  task automatic do_read(input string tag);
    int n;
    send_cmd(4'h1, 1'b1, 1'b1);
    check({tag, "_cmd_vld"}, 32'(core_if.cmd_vld), 32'd1);
    for (int i = 0; i < 32; i++) exp_rd_q.push_back(idcode[i]);
    step(1'b1);
    check({tag, "_turn_a_oe"}, 32'(dio_oe), 32'd0);
    step(1'b1);
    check({tag, "_rdata_oe"}, 32'(dio_oe), 32'd1);
    n = 0;
    while (dio_oe && n < 40) begin
      step(1'b1);
      n++;
    end
    check({tag, "_rdata_len"}, 32'(n), 32'd32);
    check({tag, "_turn_b_oe"}, 32'(dio_oe), 32'd0);
    step(1'b1);
    check({tag, "_rd_queue_left"}, 32'(exp_rd_q.size()), 32'd0);
  endtask

  initial begin
    logic [7:0] key;
    logic       b;
    int         n;

    // Reset state
    repeat (3) @(posedge dck);
    #1;
    check("rst_connected", 32'(connected), 32'd0);
    check("rst_dio_oe", 32'(dio_oe), 32'd0);
    check("rst_cmd", 32'(core_if.cmd), 32'd0);
    check("rst_cmd_vld", 32'(core_if.cmd_vld), 32'd0);
    check("rst_dio_o", 32'(dio_o), 32'(core_if.serial_rdata));
    drst_n = 1'b1;

    // Wrong key keeps the link down; correct key connects after its last bit
    repeat (4) step(1'b1);
    send_key(8'ha6);
    check("key_a6", 32'(connected), 32'd0);
    repeat (3) step(1'b1);
    key = 8'ha7;
    for (int i = 7; i >= 1; i--) step(key[i]);
    check("key_a7_partial", 32'(connected), 32'd0);
    step(key[0]);
    check("key_a7", 32'(connected), 32'd1);
    repeat (2) step(1'b1);

    // Read IDCODE
    do_read("rd1");

    // Bad parity: error pulse, no dispatch, link still accepts the next start
    send_cmd(4'h1, 1'b0, 1'b0);
    check("perr_pulse", 32'(core_if.serial_parity_err), 32'd1);
    check("perr_no_vld", 32'(core_if.cmd_vld), 32'd0);
    step(1'b1);
    check("perr_one_cycle", 32'(core_if.serial_parity_err), 32'd0);
    do_read("rd2");

    // Write: wdata follows dio_i for the 32 payload bits
    send_cmd(4'h3, 1'b0, 1'b1);
    check("wr_cmd_vld", 32'(core_if.cmd_vld), 32'd1);
    step(1'b1);
    check("wr_vld_start", 32'(core_if.serial_wdata_vld), 32'd1);
    for (int i = 0; i < 32; i++) begin
      b = 1'($urandom_range(0, 1));
      exp_wr_q.push_back(b);
      step(b);
    end
    check("wr_vld_end", 32'(core_if.serial_wdata_vld), 32'd0);
    check("wr_queue_left", 32'(exp_wr_q.size()), 32'd0);
    check("wr_dio_oe", 32'(dio_oe), 32'd0);

    // Command with no payload returns straight to idle
    send_cmd(4'h6, 1'b0, 1'b1);
    step(1'b1);
    check("nop6_wdata_vld", 32'(core_if.serial_wdata_vld), 32'd0);
    check("nop6_oe", 32'(dio_oe), 32'd0);
    do_read("rd3");

    // Core-requested disconnect
    disc_en = 1'b1;
    send_cmd(4'h0, 1'b0, 1'b1);
    check("disc_cmd_vld", 32'(core_if.cmd_vld), 32'd1);
    check("disc_still_conn", 32'(connected), 32'd1);
    step(1'b1);
    disc_en = 1'b0;
    check("disc_connected", 32'(connected), 32'd0);
    send_cmd(4'h1, 1'b1, 1'b0);
    check("disc_ignores_cmd", 32'(connected), 32'd0);
    send_key(8'ha7);
    check("reconnect", 32'(connected), 32'd1);
    step(1'b1);

    // Reset in the middle of a read payload
    send_cmd(4'h1, 1'b1, 1'b1);
    for (int i = 0; i < 32; i++) exp_rd_q.push_back(idcode[i]);
    repeat (4) step(1'b1);
    check("mid_rd_oe", 32'(dio_oe), 32'd1);
    #2;
    drst_n = 1'b0;
    #1;
    check("async_rst_oe", 32'(dio_oe), 32'd0);
    check("async_rst_conn", 32'(connected), 32'd0);
    exp_rd_q.delete();
    @(posedge dck);
    #1;
    drst_n = 1'b1;
    repeat (5) step(1'b1);
    check("post_rst_conn", 32'(connected), 32'd0);
    send_cmd(4'h1, 1'b1, 1'b0);
    check("post_rst_no_cmd", 32'(connected), 32'd0);
    send_key(8'ha7);
    check("post_rst_key", 32'(connected), 32'd1);
    step(1'b1);

`ifdef TWD_PAYLOAD_TIMEOUT_EN
    // Stalled payload: dispatch step plus 72 payload cycles, then error
    hold_payload = 1'b1;
    skip_rd      = 1'b1;
    send_cmd(4'h1, 1'b1, 1'b1);
    n = 0;
    while (!core_if.serial_parity_err && n < 200) begin
      step(1'b1);
      n++;
    end
    check("timeout_cycles", 32'(n), 32'd73);
    check("timeout_oe", 32'(dio_oe), 32'd0);
    hold_payload = 1'b0;
    skip_rd      = 1'b0;
    step(1'b1);
    do_read("rd_after_to");
`else
    n = 0;
`endif

    check("cmd_queue_left", 32'(exp_cmd_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Hard stop if the run wedges
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
